cross_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline for one shared signed cross-product unit. The geofence engines (sort pass, inside-check pass, and future parallel cores) all evaluate (x1-x0)(y2-y0) - (x2-x0)(y1-y0). Instead of each engine carrying its own pair of 11x11 multipliers, they present operand sets to this block. It grants one requester per cycle, computes the cross product at one result per cycle, and returns the result tagged with the requester index.

---
 rtl/cross_arbiter.sv | 127 ++++++++++++
 tb/tb_cross_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cross_arbiter.sv
// Round-robin arbiter in front of a shared two-stage signed cross-product pipeline.
// One grant per cycle; result returns two cycles later tagged with the requester index.
module cross_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N*10-1:0]   req_x0,
    input  logic [N*10-1:0]   req_y0,
    input  logic [N*10-1:0]   req_x1,
    input  logic [N*10-1:0]   req_y1,
    input  logic [N*10-1:0]   req_x2,
    input  logic [N*10-1:0]   req_y2,
    output logic [N-1:0]      gnt,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [20:0]       res_value,
    output logic              res_neg
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    int unsigned    idx;

    logic [9:0]  sel_x0, sel_y0, sel_x1, sel_y1, sel_x2, sel_y2;
    logic [10:0] dx1_d, dy1_d, dx2_d, dy2_d;

    logic           s1_valid_q;
    logic [IDW-1:0] s1_id_q;
    logic [10:0]    dx1_q, dy1_q, dx2_q, dy2_q;

    logic           res_valid_q;
    logic [IDW-1:0] res_id_q;
    logic [20:0]    res_value_q, res_value_d;
    logic [20:0]    e_dx1, e_dy1, e_dx2, e_dy2;

    // Scan from ptr upwards with wrap; reset forces the grant vector low.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                idx = (int'(ptr_q) + i) % N;
                if (!gnt_any && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                    gnt_any  = 1'b1;
                end
            end
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        sel_x0 = '0;
        sel_y0 = '0;
        sel_x1 = '0;
        sel_y1 = '0;
        sel_x2 = '0;
        sel_y2 = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_x0 = req_x0[10*i +: 10];
                sel_y0 = req_y0[10*i +: 10];
                sel_x1 = req_x1[10*i +: 10];
                sel_y1 = req_y1[10*i +: 10];
                sel_x2 = req_x2[10*i +: 10];
                sel_y2 = req_y2[10*i +: 10];
            end
        end
    end

    assign dx1_d = {1'b0, sel_x1} - {1'b0, sel_x0};
    assign dy1_d = {1'b0, sel_y1} - {1'b0, sel_y0};
    assign dx2_d = {1'b0, sel_x2} - {1'b0, sel_x0};
    assign dy2_d = {1'b0, sel_y2} - {1'b0, sel_y0};

    // The true result always fits 21 bits, so modulo-2^21 arithmetic on
    // sign-extended deltas yields the exact signed value.
    assign e_dx1 = {{10{dx1_q[10]}}, dx1_q};
    assign e_dy1 = {{10{dy1_q[10]}}, dy1_q};
    assign e_dx2 = {{10{dx2_q[10]}}, dx2_q};
    assign e_dy2 = {{10{dy2_q[10]}}, dy2_q};
    assign res_value_d = (e_dx1 * e_dy2) - (e_dx2 * e_dy1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            dx1_q       <= '0;
            dy1_q       <= '0;
            dx2_q       <= '0;
            dy2_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_value_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= gnt_any;
            s1_id_q     <= gnt_id;
            dx1_q       <= dx1_d;
            dy1_q       <= dy1_d;
            dx2_q       <= dx2_d;
            dy2_q       <= dy2_d;
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_id_q    <= s1_id_q;
                res_value_q <= res_value_d;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_value = res_value_q;
    assign res_neg   = res_value_q[20];

endmodule

// File: tb/tb_cross_arbiter.sv
// Directed bench for cross_arbiter: grant order, result latency/values, pointer and reset behaviour.
module tb_cross_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [39:0] x0_v, y0_v, x1_v, y1_v, x2_v, y2_v;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [20:0] res_value;
    logic        res_neg;

    int checks = 0;
    int errors = 0;

    cross_arbiter #(.N(4), .IDW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_x0    (x0_v),
        .req_y0    (y0_v),
        .req_x1    (x1_v),
        .req_y1    (y1_v),
        .req_x2    (x2_v),
        .req_y2    (y2_v),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_value (res_value),
        .res_neg   (res_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [9:0] ax0, input logic [9:0] ay0,
                           input logic [9:0] ax1, input logic [9:0] ay1,
                           input logic [9:0] ax2, input logic [9:0] ay2);
        x0_v[10*i +: 10] = ax0;
        y0_v[10*i +: 10] = ay0;
        x1_v[10*i +: 10] = ax1;
        y1_v[10*i +: 10] = ay1;
        x2_v[10*i +: 10] = ax2;
        y2_v[10*i +: 10] = ay2;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] exp);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp));
    endtask

    task automatic chk_res(input string tag, input logic [1:0] id, input logic [20:0] val);
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".id"},    32'(res_id),    32'(id));
        chk({tag, ".value"}, 32'(res_value), 32'(val));
        chk({tag, ".neg"},   32'(res_neg),   32'(val[20]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        reset = 1'b0;
        req   = 4'b1111;
        x0_v = '0; y0_v = '0; x1_v = '0; y1_v = '0; x2_v = '0; y2_v = '0;

        // Reset state
        step();
        step();
        chk_gnt("rst", 4'b0000);
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.id",    32'(res_id),    32'd0);
        chk("rst.value", 32'(res_value), 32'd0);
        chk("rst.neg",   32'(res_neg),   32'd0);
        req = 4'b0000;
        step();
        reset = 1'b1;

        // Single op, requester 0: 4*3 - 0*0 = 12
        set_ops(0, 0, 0, 4, 0, 0, 3);
        req = 4'b0001;
        chk_gnt("single", 4'b0001);
        step();
        req = 4'b0000;
        chk_idle("single.t1");
        step();
        chk_res("single", 2'd0, 21'd12);

        // Sign and id, requester 2 (ptr=1): -12
        set_ops(2, 0, 0, 0, 3, 4, 0);
        req = 4'b0100;
        chk_gnt("sign", 4'b0100);
        step();
        req = 4'b0000;
        chk_idle("sign.t1");
        chk("hold.value", 32'(res_value), 32'd12);
        step();
        chk_res("sign", 2'd2, 21'h1FFFF4);

        // Extremes back to back: req3, req0, req1 (ptr=3)
        set_ops(3, 0, 0, 1023, 0, 0, 1023);
        req = 4'b1000;
        chk_gnt("ext_a", 4'b1000);
        step();
        set_ops(0, 0, 0, 0, 1023, 1023, 0);
        req = 4'b0001;
        chk_gnt("ext_b", 4'b0001);
        step();
        set_ops(1, 5, 5, 10, 10, 20, 20);
        req = 4'b0010;
        chk_gnt("ext_c", 4'b0010);
        chk_res("ext_max", 2'd3, 21'd1046529);
        step();
        req = 4'b0000;
        chk_res("ext_min", 2'd0, 21'h1007FF);
        step();
        chk_res("collinear", 2'd1, 21'd0);
        step();
        chk_idle("ext.drain");

        // Move ptr to 0 via a lone grant to 3, then all four request continuously
        for (int i = 0; i < 4; i++) set_ops(i, 0, 0, 10'(i + 1), 0, 0, 1);
        req = 4'b1000;
        chk_gnt("rr_pre", 4'b1000);
        step();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            chk_gnt($sformatf("rr%0d", k), exp_g);
            chk($sformatf("rr%0d.onehot", k), 32'($countones(gnt) <= 1), 32'd1);
            if (k == 0) chk_idle("rr0");
            else if (k == 1) chk_res("rr1", 2'd3, 21'd4);
            else chk_res($sformatf("rr%0d", k), 2'((k - 2) % 4), 21'(((k - 2) % 4) + 1));
            step();
        end
        req = 4'b0000;
        chk_res("rr_drain0", 2'd2, 21'd3);
        step();
        chk_res("rr_drain1", 2'd3, 21'd4);
        step();
        chk_idle("rr_drain2");

        // Pointer behaviour (ptr=0)
        req = 4'b0010;
        chk_gnt("ptr_a", 4'b0010);
        step();
        req = 4'b1010;
        chk_gnt("ptr_b", 4'b1000);
        step();
        chk_gnt("ptr_c", 4'b0010);
        step();
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            chk_gnt($sformatf("gap%0d", k), 4'b0000);
            step();
        end
        req = 4'b1010;
        chk_gnt("ptr_after_gap", 4'b1000);
        step();
        req = 4'b0000;
        step();
        step();

        // Reset mid-flight: grant 2 (ptr becomes 3), then reset
        set_ops(2, 1, 1, 9, 1, 1, 9);
        req = 4'b0100;
        chk_gnt("mid_gnt", 4'b0100);
        step();
        reset = 1'b0;
        req = 4'b1111;
        chk_gnt("mid_rst", 4'b0000);
        chk("mid_rst.valid", 32'(res_valid), 32'd0);
        chk("mid_rst.id",    32'(res_id),    32'd0);
        chk("mid_rst.value", 32'(res_value), 32'd0);
        chk("mid_rst.neg",   32'(res_neg),   32'd0);
        step();
        chk_gnt("mid_rst2", 4'b0000);
        chk_idle("mid_rst2");
        step();
        reset = 1'b1;
        set_ops(3, 1, 2, 4, 6, 7, 1);
        req = 4'b1001;
        chk_gnt("post_ptr0", 4'b0001);
        chk_idle("post0");
        step();
        req = 4'b1000;
        chk_gnt("post_r3", 4'b1000);
        chk_idle("post1");
        step();
        req = 4'b0000;
        chk_res("post_r0", 2'd0, 21'd1);
        step();
        chk_res("post_r3", 2'd3, 21'h1FFFE5);
        step();
        chk_idle("post_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
